// File: rtl/rr_arb10.sv
// Ten-requester round-robin arbiter with registered one-hot grant and an
// optional hold timeout that forces the owner off the resource.
module rr_arb10 #(
  parameter int NREQ    = 10,
  parameter int MAXHOLD = 16
) (
  input  logic            CK,
  input  logic            CD,
  input  logic [NREQ-1:0] REQ,
  input  logic            DONE,
  output logic [NREQ-1:0] GNT,
  output logic [3:0]      GNTID,
  output logic            BUSY,
  output logic            TIMEOUT,
  output logic            IDLE
);

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [3:0] ptr;
  logic [7:0] tmr;

  logic       found;
  logic [3:0] win;
  logic [4:0] sum;
  logic [3:0] idx;
  logic       own_req;
  logic       tmo_hit;
  logic       release_now;

  // Rotating search: first set request starting at ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = 4'd0;
    sum   = 5'd0;
    idx   = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + 5'(i);
      if (sum >= 5'(NREQ)) sum = sum - 5'(NREQ);
      idx = sum[3:0];
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign own_req     = REQ[GNTID];
  assign tmo_hit     = (MAXHOLD != 0) && (tmr == 8'(MAXHOLD - 1));
  assign release_now = !own_req || DONE || tmo_hit;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state   <= ARB;
      ptr     <= 4'd0;
      tmr     <= 8'd0;
      GNT     <= '0;
      GNTID   <= 4'd0;
      TIMEOUT <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        ARB: begin
          if (found) begin
            GNT   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            GNTID <= win;
            tmr   <= 8'd0;
            state <= GRANT;
          end
        end
        default: begin
          if (release_now) begin
            GNT     <= '0;
            GNTID   <= 4'd0;
            ptr     <= (GNTID == 4'(NREQ - 1)) ? 4'd0 : GNTID + 4'd1;
            // Only a pure timer expiry counts as a forced release.
            TIMEOUT <= tmo_hit && own_req && !DONE;
            state   <= ARB;
          end else if (tmr != 8'hFF) begin
            tmr <= tmr + 8'd1;
          end
        end
      endcase
    end
  end

  assign BUSY = |GNT;
  assign IDLE = ~|REQ;

endmodule

// File: tb/tb_rr_arb10.sv
// Bench for rr_arb10: two instances (timeout 4 and timeout disabled) share
// stimulus; a cycle model of ownership is compared against both every cycle.
module tb_rr_arb10;

  logic       CK, CD, DONE;
  logic [9:0] REQ;
  logic [9:0] g4, g0;
  logic [3:0] id4, id0;
  logic       b4, b0, t4, t0, i4, i0;

  int checks = 0;
  int errors = 0;

  rr_arb10 #(.NREQ(10), .MAXHOLD(4)) u4 (
    .CK(CK), .CD(CD), .REQ(REQ), .DONE(DONE),
    .GNT(g4), .GNTID(id4), .BUSY(b4), .TIMEOUT(t4), .IDLE(i4)
  );
  rr_arb10 #(.NREQ(10), .MAXHOLD(0)) u0 (
    .CK(CK), .CD(CD), .REQ(REQ), .DONE(DONE),
    .GNT(g0), .GNTID(id0), .BUSY(b0), .TIMEOUT(t0), .IDLE(i0)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = none), cycles held so far, next search start.
  int m_own [2];
  int m_cnt [2];
  int m_ptr [2];
  bit m_to  [2];
  int mh    [2] = '{4, 0};

  always @(posedge CK or posedge CD) begin
    for (int k = 0; k < 2; k++) begin
      if (CD) begin
        m_own[k] = -1; m_cnt[k] = 0; m_ptr[k] = 0; m_to[k] = 0;
      end else begin
        m_to[k] = 0;
        if (m_own[k] < 0) begin
          int w;
          w = -1;
          for (int j = 0; j < 10; j++) begin
            int c;
            logic [9:0] sh;
            c  = (m_ptr[k] + j) % 10;
            sh = REQ >> c;
            if (w < 0 && sh[0]) w = c;
          end
          if (w >= 0) begin
            m_own[k] = w; m_cnt[k] = 1;
          end
        end else begin
          logic [9:0] sh;
          bit dropped, expired;
          sh      = REQ >> m_own[k];
          dropped = !sh[0];
          expired = (mh[k] != 0) && (m_cnt[k] == mh[k]);
          if (dropped || DONE || expired) begin
            m_to[k]  = expired && !dropped && !DONE;
            m_ptr[k] = (m_own[k] + 1) % 10;
            m_own[k] = -1;
            m_cnt[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  end

  function automatic logic [9:0] exp_gnt(input int own);
    return (own >= 0) ? (10'd1 << own) : 10'd0;
  endfunction

  always @(negedge CK) begin
    chk("gnt_h4",   32'(g4),  32'(exp_gnt(m_own[0])));
    chk("gntid_h4", 32'(id4), (m_own[0] >= 0) ? m_own[0] : 0);
    chk("busy_h4",  32'(b4),  32'(m_own[0] >= 0));
    chk("tmo_h4",   32'(t4),  32'(m_to[0]));
    chk("gnt_h0",   32'(g0),  32'(exp_gnt(m_own[1])));
    chk("gntid_h0", 32'(id0), (m_own[1] >= 0) ? m_own[1] : 0);
    chk("busy_h0",  32'(b0),  32'(m_own[1] >= 0));
    chk("tmo_h0",   32'(t0),  32'(m_to[1]));
    chk("idle",     32'(i4),  32'(REQ == 10'd0));
  end

  task automatic cyc();
    @(posedge CK);
    #2;
  endtask

  task automatic pulse_reset();
    CD = 1'b1;
    #1;
    CD = 1'b0;
  endtask

  int drops, tos;

  initial begin
    CD = 1'b1; REQ = '0; DONE = 1'b0;
    #1;
    chk("rst_gnt", 32'(g4), 0);
    chk("rst_gntid", 32'(id4), 0);
    chk("rst_busy", 32'(b4), 0);
    chk("rst_tmo", 32'(t4), 0);
    chk("rst_idle", 32'(i4), 1);
    cyc(); cyc();
    CD = 1'b0;

    // Single requester, release by dropping REQ.
    REQ = 10'h001;
    cyc();
    chk("t1_gnt", 32'(g4), 32'h001);
    chk("t1_id", 32'(id4), 0);
    chk("t1_busy", 32'(b4), 1);
    REQ = 10'h000;
    cyc();
    chk("t1_rel", 32'(g4), 0);
    REQ = 10'h003;
    cyc();
    chk("t1_ptr1", 32'(id4), 1);
    REQ = 10'h000;
    cyc(); cyc();

    // Full rotation, DONE in the third cycle of every grant.
    pulse_reset();
    REQ = 10'h3FF;
    for (int i = 0; i <= 10; i++) begin
      cyc();
      chk("t2_rot", 32'(id4), i % 10);
      cyc(); cyc();
      chk("t2_hold", 32'(g4), 32'(10'd1 << (i % 10)));
      DONE = 1'b1;
      cyc();
      DONE = 1'b0;
      chk("t2_dead", 32'(g4), 0);
    end
    REQ = 10'h000;
    cyc(); cyc();

    // Timeout with two contenders, pointer wrap from 9 back to 0.
    pulse_reset();
    REQ = 10'h201;
    cyc();
    chk("t3_g0", 32'(id4), 0);
    cyc(); cyc(); cyc();
    chk("t3_hold4", 32'(g4), 32'h001);
    cyc();
    chk("t3_tmo", 32'(t4), 1);
    chk("t3_rel", 32'(g4), 0);
    cyc();
    chk("t3_g9", 32'(id4), 9);
    chk("t3_tmo_clr", 32'(t4), 0);
    cyc(); cyc(); cyc(); cyc();
    chk("t3_tmo9", 32'(t4), 1);
    cyc();
    chk("t3_wrap", 32'(id4), 0);
    REQ = 10'h000;
    cyc(); cyc();

    // DONE on the expiry edge, then REQ drop plus DONE together.
    pulse_reset();
    REQ = 10'h004;
    cyc(); cyc(); cyc(); cyc();
    DONE = 1'b1;
    cyc();
    DONE = 1'b0;
    chk("t4_rel", 32'(g4), 0);
    chk("t4_notmo", 32'(t4), 0);
    REQ = 10'h018;
    cyc();
    chk("t4_g3", 32'(id4), 3);
    cyc();
    REQ = 10'h030; DONE = 1'b1;
    cyc();
    DONE = 1'b0;
    chk("t4_rel2", 32'(g4), 0);
    cyc();
    chk("t4_ptr_plus1", 32'(id4), 4);
    REQ = 10'h000;
    cyc(); cyc();

    // Asynchronous reset in the middle of a grant.
    pulse_reset();
    REQ = 10'h020;
    cyc();
    chk("t5_g5", 32'(id4), 5);
    CD = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(g4), 0);
    chk("t5_async_id", 32'(id4), 0);
    chk("t5_async_busy", 32'(b4), 0);
    chk("t5_async_tmo", 32'(t4), 0);
    chk("t5_idle_rst", 32'(i4), 0);
    REQ = 10'h000;
    #1;
    chk("t5_idle_rst1", 32'(i4), 1);
    REQ = 10'h060;
    cyc();
    CD = 1'b0;
    cyc();
    chk("t5_after", 32'(id4), 5);
    REQ = 10'h000;
    cyc(); cyc();

    // IDLE follows every single request bit combinationally.
    for (int i = 0; i < 10; i++) begin
      REQ = 10'd1 << i;
      #1;
      chk("t6_idle", 32'(i4), 0);
    end
    REQ = 10'h000;
    cyc(); cyc();

    // Timeout disabled: the grant must survive 300 cycles.
    pulse_reset();
    REQ = 10'h001;
    cyc();
    drops = 0; tos = 0;
    repeat (300) begin
      cyc();
      if (g0 !== 10'h001) drops++;
      if (t0 !== 1'b0) tos++;
    end
    chk("t7_nodrop", 32'(drops), 0);
    chk("t7_notmo", 32'(tos), 0);
    REQ = 10'h000;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb10.md
Name: rr_arb10

Overview:
- Ten-requester round-robin arbiter for one shared schematic-level resource.
- Requests are gated into the resource by one-hot grants.
- A NOR of all requests drives the idle flag.
- Sits between up to ten macro-level clients and one shared bus, LUT bank or port, and sequences exclusive ownership with optional hold-timeout.

Parameters:
- NREQ, 10, number of requesters; fixed at 10; GNTID width 4.
- MAXHOLD, 16, maximum grant length in cycles (1..255); 0 disables the timeout.

Ports:
- CK  input  1  clock, rising edge.
- CD  input  1  asynchronous active-high reset (clear direct).
- REQ  input  10  request per client; level, held until served.
- DONE  input  1  owner releases the resource; sampled only in GRANT.
- GNT  output  10  one-hot grant, registered.
- GNTID  output  4  binary index of the granted client; 0 when no grant.
- BUSY  output  1  high while any GNT bit is high.
- TIMEOUT  output  1  one-cycle pulse on forced release.
- IDLE  output  1  combinational NOR of REQ[9:0].

Behaviour:
- Reset (CD high, asynchronous):
  - GNT=0, GNTID=0, BUSY=0, TIMEOUT=0.
  - Priority pointer PTR=0; hold timer TMR=0 (8-bit); state ARB.
  - Deassertion of CD is synchronised by the user. The first edge after release evaluates ARB.
- Reset mid-grant drops GNT immediately and restores PTR=0.
- State ARB:
  - If REQ==0, stay in ARB with outputs 0.
  - Otherwise select the first set REQ bit searching PTR, PTR+1, …, 9, 0, …, PTR-1.
  - At the next edge: GNT=one-hot(winner), GNTID=winner, BUSY=1, TMR=0, state GRANT.
  - REQ-to-GNT latency is 1 cycle.
- State GRANT, evaluated every edge; O is the owner:
  - Release if REQ[O]==0, or DONE==1, or (MAXHOLD!=0 and TMR==MAXHOLD-1).
  - Otherwise TMR<=TMR+1 (saturating at 255) and GNT is held.
- On release (next edge):
  - GNT=0, GNTID=0, BUSY=0.
  - PTR=(O+1) mod 10, wrapping 9 to 0.
  - State ARB.
  - TIMEOUT=1 for that one cycle only if release was caused solely by the timer.
- There is always one dead cycle (GNT=0) between consecutive grants. The back-to-back grant period is hold+1 cycles.
- No preemption: REQ changes of non-owners during GRANT are ignored.
- Simultaneous events:
  - DONE together with timer expiry: release with TIMEOUT=0.
  - REQ[O] drop together with DONE: a single release.
- The same client can be re-granted immediately after ARB only if no other REQ bit is set. The rotated PTR still places it last.
- With MAXHOLD=1 every grant lasts exactly 1 cycle.
- IDLE has no register and follows REQ combinationally, including during reset.
- GNT is always one-hot or zero. GNTID always matches the GNT encoding.

Test Plan:
- Reset, then REQ=10'h001 -> GNT=10'h001, GNTID=0, BUSY=1 one cycle later. Drop REQ -> GNT=0 next cycle, PTR=1.
- REQ=10'h3FF held, DONE pulsed after 2 cycles in each grant -> grants rotate 0,1,2,…,9,0. Each grant is 3 cycles, separated by one GNT=0 cycle.
- MAXHOLD=4, REQ=10'h201 held, DONE=0:
  - Client 0 holds 4 cycles, then TIMEOUT=1 for 1 cycle and GNT=0.
  - Next, client 9 is granted (GNTID=9).
  - After that release, PTR wraps to 0.
- DONE asserted on the same edge as TMR==MAXHOLD-1 -> release with TIMEOUT=0. Owner REQ drop plus DONE together -> one release, PTR advances by exactly one.
- CD asserted asynchronously mid-grant (GNTID=5) -> GNT, GNTID, BUSY, TIMEOUT are 0 immediately, without a clock edge. After release with REQ=10'h060, client 5 is granted (PTR=0 search).
- REQ=0 -> IDLE=1. Any single REQ bit set -> IDLE=0 in the same cycle, including while CD=1. MAXHOLD=0 with REQ held -> grant is never released and TIMEOUT never asserts over 300 cycles.
